// File: rtl/stack_game_fsm.sv
// Gameplay controller for the block-stacking game: owns row/score/chances/level,
// generates the level-dependent shift tick, and handles pause, win and lose.
module stack_game_fsm #(
    parameter int NUM_ROWS       = 16,
    parameter int MAX_CHANCES    = 3,
    parameter int SCORE_W        = 8,
    parameter int BASE_PERIOD    = 8,
    parameter int PERIOD_STEP    = 1,
    parameter int MIN_PERIOD     = 2,
    parameter int ROWS_PER_LEVEL = 4,
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CW = $clog2(MAX_CHANCES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_place,
    input  logic               key_pause,
    input  logic               overlap_ok,
    output logic               load,
    output logic               shift_en,
    output logic               save_x,
    output logic [RW-1:0]      row,
    output logic [SCORE_W-1:0] score,
    output logic [CW-1:0]      chances,
    output logic [3:0]         level,
    output logic [1:0]         game_status
);

    localparam int PMAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
    localparam int TW   = $clog2(PMAX + 1);

    typedef enum logic [3:0] {
        S_START, S_PREP, S_RUN, S_PAUSED, S_JUDGE, S_SUCCESS, S_FAIL, S_WIN, S_LOSE
    } state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CW-1:0]      chances_q, chances_d;
    logic [3:0]         level_q, level_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic               place_q, pause_q, press_q, pause_t_q;
    logic [TW-1:0]      period;
    int                 p_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_START;
            row_q     <= '0;
            score_q   <= '0;
            chances_q <= CW'(MAX_CHANCES);
            level_q   <= '0;
            tick_q    <= '0;
            place_q   <= 1'b0;
            pause_q   <= 1'b0;
            press_q   <= 1'b0;
            pause_t_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            score_q   <= score_d;
            chances_q <= chances_d;
            level_q   <= level_d;
            tick_q    <= tick_d;
            place_q   <= key_place;
            pause_q   <= key_pause;
            press_q   <= key_place & ~place_q;
            pause_t_q <= key_pause & ~pause_q;
        end
    end

    // Shift period shrinks with level down to the floor.
    always_comb begin
        p_raw = BASE_PERIOD - int'(level_q) * PERIOD_STEP;
        if (p_raw < MIN_PERIOD) p_raw = MIN_PERIOD;
        period = TW'(p_raw);
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        score_d     = score_q;
        chances_d   = chances_q;
        level_d     = level_q;
        tick_d      = tick_q;
        load        = 1'b0;
        shift_en    = 1'b0;
        save_x      = 1'b0;
        game_status = 2'b01;
        case (state_q)
            S_START: state_d = S_PREP;
            S_PREP: begin
                load    = 1'b1;
                tick_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // tick counts 1..P; the pulse fires on the cycle it reaches P
                shift_en = (tick_q >= period);
                tick_d   = shift_en ? TW'(1) : tick_q + 1'b1;
                if (press_q)        state_d = (row_q == '0) ? S_SUCCESS : S_JUDGE;
                else if (pause_t_q) state_d = S_PAUSED;
            end
            S_PAUSED: begin
                game_status = 2'b00;
                if (pause_t_q) state_d = S_RUN;
            end
            S_JUDGE: state_d = overlap_ok ? S_SUCCESS : S_FAIL;
            S_SUCCESS: begin
                save_x = 1'b1;
                if (score_q != '1) score_d = score_q + 1'b1;
                if (row_q == RW'(NUM_ROWS - 1)) begin
                    state_d = S_WIN;
                end else begin
                    row_d = row_q + 1'b1;
                    if (((int'(row_q) + 1) % ROWS_PER_LEVEL == 0) && (level_q != 4'hf))
                        level_d = level_q + 4'd1;
                    state_d = S_PREP;
                end
            end
            S_FAIL: begin
                if (chances_q <= CW'(1)) begin
                    chances_d = '0;
                    state_d   = S_LOSE;
                end else begin
                    chances_d = chances_q - 1'b1;
                    state_d   = S_PREP;
                end
            end
            S_WIN, S_LOSE: begin
                game_status = (state_q == S_WIN) ? 2'b11 : 2'b10;
                if (press_q) begin
                    state_d   = S_START;
                    row_d     = '0;
                    score_d   = '0;
                    level_d   = '0;
                    chances_d = CW'(MAX_CHANCES);
                end
            end
            default: state_d = S_START;
        endcase
    end

    assign row     = row_q;
    assign score   = score_q;
    assign chances = chances_q;
    assign level   = level_q;

endmodule

// File: doc/stack_game_fsm.md
Name: stack_game_fsm

Overview:
Parametrised gameplay controller for the block-stacking game, succeeding the fixed 10-state controller. It owns the row, score, chances and level counters internally, generates its own shift-enable tick whose rate rises with level, and supports pause, win and lose outcomes. It drives the gameplay datapath (x/y/direction registers) and feeds game_status to the display FSM.

Parameters:
NUM_ROWS, 16, rows to stack; topping row NUM_ROWS-1 wins
MAX_CHANCES, 3, failed placements allowed before game over
SCORE_W, 8, score counter width
BASE_PERIOD, 8, clocks between shift_en pulses at level 0
PERIOD_STEP, 1, period reduction per level
MIN_PERIOD, 2, period floor
ROWS_PER_LEVEL, 4, successful rows per level increment

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
key_place  in  1  place key level, active-high, synchronous to clk
key_pause  in  1  pause key level, active-high
overlap_ok  in  1  datapath overlap result, valid while state JUDGE
load  out  1  one-cycle pulse: parallel-load x, y, direction
shift_en  out  1  one-cycle pulse: datapath advances x by one
save_x  out  1  one-cycle pulse: latch current x as prev_x
row  out  clog2(NUM_ROWS)  current row index
score  out  SCORE_W  successful placements, saturating
chances  out  clog2(MAX_CHANCES+1)  remaining chances
level  out  4  speed level, saturates at 15
game_status  out  2  00 paused, 01 playing, 10 lost, 11 won

Behaviour:
- Reset (sync, active-high): state START; row=0, score=0, chances=MAX_CHANCES, level=0, game_status=01, load/shift_en/save_x=0, edge registers cleared, tick counter 0.
- Edge detect: press = key_place & ~key_place_q; pause_t = key_pause & ~key_pause_q; registered, so FSM reacts one cycle after the key rises. A held key counts once.
- States (Moore outputs):
  START: no pulses; -> PREP.
  PREP: load=1; tick counter cleared; -> RUN.
  RUN: shift_en pulses once every P cycles, first pulse P cycles after entry. P = max(MIN_PERIOD, BASE_PERIOD - level*PERIOD_STEP). press -> SUCCESS if row==0, else JUDGE. pause_t (press not set) -> PAUSED. press and pause_t in the same cycle: press wins.
  PAUSED: game_status=00; no shift_en; tick counter held; press ignored; pause_t -> RUN, resuming the tick count where it stopped.
  JUDGE: sample overlap_ok; 1 -> SUCCESS, 0 -> FAIL.
  SUCCESS: save_x=1; score+1 (saturates at all-ones). If row==NUM_ROWS-1 -> WIN, row unchanged. Else row+1; level+1 (sat 15) when new row is a nonzero multiple of ROWS_PER_LEVEL; -> PREP.
  FAIL: chances-1. If chances was 1 -> LOSE (chances=0). Else -> PREP, same row reloaded.
  WIN: game_status=11. LOSE: game_status=10. In both: press -> START with row/score/level cleared and chances=MAX_CHANCES in the same update. All other inputs ignored.
- Row 0 never consults overlap_ok and never costs a chance.
- overlap_ok is ignored outside JUDGE.
- Key events are ignored in START, PREP, JUDGE, SUCCESS and FAIL (edge is consumed, not queued).
- Reset mid-game in any state returns to reset values on the next edge. No partial counter updates are kept.
- Counter updates occur on the clock edge leaving SUCCESS/FAIL. Outputs reflect the new values the following cycle.

Test Plan:
All tests use NUM_ROWS=4, MAX_CHANCES=2, BASE_PERIOD=4, MIN_PERIOD=2, PERIOD_STEP=1, ROWS_PER_LEVEL=2.
- Reset, then idle 12 cycles -> load pulses once (2nd cycle after reset release); shift_en pulses every 4 cycles; game_status=01, chances=2.
- Press in row 0 with overlap_ok=0 -> SUCCESS without JUDGE; save_x=1; row=1, score=1, chances=2; load pulses next.
- Rows 1 and 2 placed with overlap_ok=1 -> row=2 gives level=1 and shift_en period 3. Row 3 success -> score=4, game_status=11, row stays 3.
- Two JUDGE failures on row 1 -> chances 2->1 (row=1, load again) then 1->0, game_status=10. A press then gives row=0, score=0, chances=2, status=01.
- Pause edge in RUN, hold 10 cycles with presses -> status=00, no shift_en, no state change. Second pause edge resumes; next shift_en lands at remaining count.
- Place and pause rising in the same cycle -> placement taken, no pause. Reset asserted in JUDGE -> all outputs at reset values next cycle.
